// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot dead time and per-frame shadowing.
// Optional SEG_DIM_EN adds a 4-bit brightness input that PWM-gates the on phase.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q;
  logic [DIGITS-1:0]   sh_dp_q, sh_mask_q;
  logic [DIGITS-1:0]   an_d;
  logic [7:0]          seg_d;
  logic                last_cnt, last_idx, frame_end, drive;
  logic [3:0]          digit;

`ifdef SEG_DIM_EN
  logic [3:0] pwm_q, pwm_d, pwm_cur;
`endif

  // Active-low segment pattern CA..CG for one hex digit.
  function automatic logic [6:0] decode_hex(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    last_cnt  = (cnt_q == CntLast);
    last_idx  = (idx_q == IdxLast);
    frame_end = en && last_cnt && last_idx;

    cnt_d = '0;
    idx_d = '0;
    if (en) begin
      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (last_cnt) idx_d = last_idx ? '0 : idx_q + 1'b1;
    end

    digit = sh_data_q[{idx_q, 2'b00} +: 4];
    drive = en && (cnt_q >= CntBlank) && !sh_mask_q[idx_q];

`ifdef SEG_DIM_EN
    // PWM phase restarts at the first on-phase cycle of every slot.
    pwm_cur = (cnt_q == CntBlank) ? 4'h0 : pwm_q;
    pwm_d   = pwm_cur + 4'h1;
    drive   = drive && ((brightness == 4'hF) || (pwm_cur < brightness));
`endif

    an_d  = '1;
    seg_d = 8'hFF;
    if (drive) begin
      an_d[idx_q] = 1'b0;
      seg_d       = {~sh_dp_q[idx_q], decode_hex(digit)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_mask_q  <= '0;
      AN         <= '1;
      SEG        <= 8'hFF;
      frame_done <= 1'b0;
`ifdef SEG_DIM_EN
      pwm_q      <= 4'h0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      AN         <= an_d;
      SEG        <= seg_d;
      frame_done <= frame_end;
`ifdef SEG_DIM_EN
      pwm_q      <= pwm_d;
`endif
      if (frame_end) begin
        sh_data_q <= data;
        sh_dp_q   <= dp;
        sh_mask_q <= blank_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-position reference model.
// Define SEG_DIM_EN for both files to exercise the brightness gating with a 34-cycle slot.
module tb_seg_scan_ctrl;

  localparam int ND = 8;
`ifdef SEG_DIM_EN
  localparam int SD = 34;
`else
  localparam int SD = 8;
`endif
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [31:0]   data = '0;
  logic [7:0]    dp = '0;
  logic [7:0]    blank_mask = '0;
  logic [3:0]    brightness = 4'hF;
  logic [7:0]    SEG;
  logic [7:0]    AN;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: flat position within the frame plus the captured shadow.
  int          m_pos = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0, m_mask = '0;
  logic [7:0]  exp_an, exp_seg;
  logic        exp_fd;
  logic [7:0]  hex_seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .dp         (dp),
    .blank_mask (blank_mask),
`ifdef SEG_DIM_EN
    .brightness (brightness),
`endif
    .SEG        (SEG),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int c, d, o, b;
    @(posedge clk);
    cyc++;
`ifdef SEG_DIM_EN
    b = int'(brightness);
`else
    b = 15;
`endif
    exp_an  = 8'hFF;
    exp_seg = 8'hFF;
    exp_fd  = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_data = '0; m_dp = '0; m_mask = '0;
    end else if (!en) begin
      m_pos = 0;
    end else begin
      c = m_pos % SD;
      d = m_pos / SD;
      o = c - BC;
      exp_fd = (m_pos == FRAME - 1);
      if (c >= BC && !m_mask[d] && (b == 15 || (o % 16) < b)) begin
        exp_an[d]  = 1'b0;
        exp_seg    = hex_seg[m_data[4*d +: 4]];
        exp_seg[7] = ~m_dp[d];
      end
      if (exp_fd) begin
        m_data = data; m_dp = dp; m_mask = blank_mask;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    data  = $urandom;
    tick();
    tick();
    checks++;
    if (AN !== 8'hFF) begin
      failures++; $display("FAIL reset_an got=%h want=ff", AN);
    end
    checks++;
    if (SEG !== 8'hFF) begin
      failures++; $display("FAIL reset_seg got=%h want=ff", SEG);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_fd got=%b want=0", frame_done);
    end
  endtask

  task automatic test_scan();
    data = 32'h0123_4567; dp = '0; blank_mask = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (AN !== exp_an || SEG !== exp_seg || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL scan_model i=%0d AN=%h/%h SEG=%h/%h fd=%b/%b",
                 i, AN, exp_an, SEG, exp_seg, frame_done, exp_fd);
      end
      if (i < FRAME && (i % SD) >= BC) begin
        checks++;
        if (SEG !== 8'hC0) begin
          failures++; $display("FAIL scan_frame1_zero i=%0d got=%h want=c0", i, SEG);
        end
      end
      if (i >= FRAME && i < FRAME + BC) begin
        checks++;
        if (AN !== 8'hFF) begin
          failures++; $display("FAIL scan_slot0_blank i=%0d got=%h want=ff", i, AN);
        end
      end
      if (i >= FRAME + BC && i < FRAME + SD) begin
        checks++;
        if (AN !== 8'hFE || SEG !== 8'hF8) begin
          failures++; $display("FAIL scan_slot0_on i=%0d AN=%h SEG=%h want fe/f8", i, AN, SEG);
        end
      end
      if (i >= 2 * FRAME - SD + BC) begin
        checks++;
        if (AN !== 8'h7F || SEG !== 8'hC0) begin
          failures++; $display("FAIL scan_slot7_on i=%0d AN=%h SEG=%h want 7f/c0", i, AN, SEG);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    int last_fd = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if (AN !== exp_an || SEG !== exp_seg || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL mid_model i=%0d AN=%h/%h SEG=%h/%h fd=%b/%b",
                 i, AN, exp_an, SEG, exp_seg, frame_done, exp_fd);
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (cyc - last_fd != FRAME) begin
            failures++; $display("FAIL fd_period got=%0d want=%0d", cyc - last_fd, FRAME);
          end
        end
        last_fd = cyc;
      end
      if ((i % FRAME) == FRAME / 2 + 3) data = $urandom;
    end
    checks++;
    if (last_fd != cyc) begin
      failures++; $display("FAIL fd_last got=%0d want=%0d", last_fd, cyc);
    end
  endtask

  task automatic test_dp_mask();
    dp = 8'h01; blank_mask = 8'h80;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (AN !== exp_an || SEG !== exp_seg || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL dpm_model i=%0d AN=%h/%h SEG=%h/%h fd=%b/%b",
                 i, AN, exp_an, SEG, exp_seg, frame_done, exp_fd);
      end
      if (i >= FRAME + BC && i < FRAME + SD) begin
        checks++;
        if (AN !== 8'hFE || SEG[7] !== 1'b0) begin
          failures++; $display("FAIL dp_digit0 i=%0d AN=%h SEG=%h want fe/dp lit", i, AN, SEG);
        end
      end
      if (i >= 2 * FRAME - SD) begin
        checks++;
        if (AN !== 8'hFF || SEG !== 8'hFF) begin
          failures++; $display("FAIL mask_digit7 i=%0d AN=%h SEG=%h want ff/ff", i, AN, SEG);
        end
      end
    end
  endtask

  task automatic test_enable();
    int guard = 0;
    while (m_pos != 3 * SD + 5 && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    checks++;
    if (m_pos != 3 * SD + 5) begin
      failures++; $display("FAIL en_align got=%0d want=%0d", m_pos, 3 * SD + 5);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (AN !== 8'hFF || SEG !== 8'hFF || frame_done !== 1'b0) begin
        failures++; $display("FAIL en_off i=%0d AN=%h SEG=%h fd=%b want ff/ff/0", i, AN, SEG,
                             frame_done);
      end
    end
    en = 1'b1;
    for (int i = 0; i < SD; i++) begin
      tick();
      checks++;
      if (AN !== ((i < BC) ? 8'hFF : 8'hFE)) begin
        failures++; $display("FAIL en_restart i=%0d got=%h want=%h", i, AN,
                             (i < BC) ? 8'hFF : 8'hFE);
      end
      checks++;
      if (AN !== exp_an || SEG !== exp_seg || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL en_model i=%0d AN=%h/%h SEG=%h/%h fd=%b/%b",
                 i, AN, exp_an, SEG, exp_seg, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) data = $urandom;
      if ($urandom_range(0, 7) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 8'($urandom);
      en = ($urandom_range(0, 99) != 0);
`ifdef SEG_DIM_EN
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
      checks++;
      if (AN !== exp_an || SEG !== exp_seg || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL rand_model i=%0d AN=%h/%h SEG=%h/%h fd=%b/%b",
                 i, AN, exp_an, SEG, exp_seg, frame_done, exp_fd);
      end
    end
    en = 1'b1; rst_n = 1'b1; brightness = 4'hF;
  endtask

`ifdef SEG_DIM_EN
  task automatic test_dim();
    int lit;
    blank_mask = '0;
    for (int i = 0; i < 2 * FRAME && m_pos != 0; i++) tick();
    for (int i = 0; i < FRAME; i++) tick();
    for (int pass = 0; pass < 2; pass++) begin
      brightness = (pass == 0) ? 4'h0 : 4'h8;
      lit = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (AN === 8'hFE) lit++;
        checks++;
        if (AN !== exp_an || SEG !== exp_seg) begin
          failures++; $display("FAIL dim_model i=%0d AN=%h/%h SEG=%h/%h", i, AN, exp_an,
                               SEG, exp_seg);
        end
      end
      checks++;
      if (lit != ((pass == 0) ? 0 : 16)) begin
        failures++; $display("FAIL dim_count b=%0d got=%0d want=%0d", brightness, lit,
                             (pass == 0) ? 0 : 16);
      end
    end
    brightness = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_mid_frame();
    test_dp_mask();
    test_enable();
    test_random();
`ifdef SEG_DIM_EN
    test_dim();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
